// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low team encodings, reader FSM states, lookup result type.
// Pure declarations; no timing or backpressure.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        TRACK = 1'b0,
        HOLD  = 1'b1
    } state_t;

    typedef struct packed {
        logic       legal;
        logic       is_blank;
        logic [3:0] nibble;
    } seg_info_t;

endpackage

// File: rtl/seg7_reader_if.sv
// Segment read-back bus: pattern/enable in, decoded value and event pulses out.
// Master drives hin/en, slave returns registered results; no backpressure.
interface seg7_reader_if;
    logic [6:0] hin;
    logic       en;
    logic [3:0] val;
    logic       valid;
    logic       err;
    logic       blank;
    logic [3:0] cnt;

    modport master (output hin, en, input val, valid, err, blank, cnt);
    modport slave  (input hin, en, output val, valid, err, blank, cnt);
endinterface

// File: rtl/seg7_lookup.sv
// Combinational active-low segment pattern -> {legal, is_blank, nibble} decode.
// Zero latency, no backpressure.
module seg7_lookup
    import seg7_pkg::*;
(
    input  logic [6:0] pat,
    output seg_info_t  info
);

    always_comb begin
        info = '{legal: 1'b0, is_blank: 1'b0, nibble: 4'h0};
        case (pat)
            SEG_0:     info = '{legal: 1'b1, is_blank: 1'b0, nibble: 4'h0};
            SEG_1:     info = '{legal: 1'b1, is_blank: 1'b0, nibble: 4'h1};
            SEG_2:     info = '{legal: 1'b1, is_blank: 1'b0, nibble: 4'h2};
            SEG_3:     info = '{legal: 1'b1, is_blank: 1'b0, nibble: 4'h3};
            SEG_4:     info = '{legal: 1'b1, is_blank: 1'b0, nibble: 4'h4};
            SEG_5:     info = '{legal: 1'b1, is_blank: 1'b0, nibble: 4'h5};
            SEG_6:     info = '{legal: 1'b1, is_blank: 1'b0, nibble: 4'h6};
            SEG_7:     info = '{legal: 1'b1, is_blank: 1'b0, nibble: 4'h7};
            SEG_8:     info = '{legal: 1'b1, is_blank: 1'b0, nibble: 4'h8};
            SEG_9:     info = '{legal: 1'b1, is_blank: 1'b0, nibble: 4'h9};
            SEG_A:     info = '{legal: 1'b1, is_blank: 1'b0, nibble: 4'hA};
            SEG_B:     info = '{legal: 1'b1, is_blank: 1'b0, nibble: 4'hB};
            SEG_C:     info = '{legal: 1'b1, is_blank: 1'b0, nibble: 4'hC};
            SEG_D:     info = '{legal: 1'b1, is_blank: 1'b0, nibble: 4'hD};
            SEG_E:     info = '{legal: 1'b1, is_blank: 1'b0, nibble: 4'hE};
            SEG_F:     info = '{legal: 1'b1, is_blank: 1'b0, nibble: 4'hF};
            SEG_BLANK: info = '{legal: 1'b0, is_blank: 1'b1, nibble: 4'h0};
            default:   info = '{legal: 1'b0, is_blank: 1'b0, nibble: 4'h0};
        endcase
    end

endmodule

// File: rtl/seg7_reader.sv
// Stability-filtered 7-segment read-back: decodes newly stable patterns, pulses valid/err, BCD-counts digits.
// Events appear the cycle after the STABLE_CYCLES-th enabled matching edge; en low simply pauses, no backpressure.
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
)(
    input  logic          clk,
    input  logic          rst,
    seg7_reader_if.slave  bus
);

    localparam logic [7:0] STAB_TGT = 8'(STABLE_CYCLES);

    logic [6:0] cand;
    logic [7:0] stab;
    state_t     state;
    seg_info_t  info;

    logic       new_pat;
    logic       stab_done;
    logic       accept;

    logic [3:0] val_q;
    logic [3:0] cnt_q;
    logic       valid_q;
    logic       err_q;
    logic       blank_q;

    // Decode the live input: on any accepting edge hin equals the pattern being accepted.
    seg7_lookup u_lookup (
        .pat  (bus.hin),
        .info (info)
    );

    always_comb begin
        new_pat   = bus.en && (bus.hin != cand);
        stab_done = bus.en && !new_pat && (state == TRACK) && ((stab + 8'd1) == STAB_TGT);
        accept    = (new_pat && (STABLE_CYCLES == 1)) || stab_done;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cand    <= SEG_BLANK;
            stab    <= 8'd0;
            state   <= HOLD;
            val_q   <= 4'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            blank_q <= 1'b1;
            cnt_q   <= 4'd0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;

            if (new_pat) begin
                cand  <= bus.hin;
                stab  <= 8'd1;
                state <= (STABLE_CYCLES == 1) ? HOLD : TRACK;
            end else if (bus.en && (state == TRACK)) begin
                stab <= stab + 8'd1;
                if (stab_done) begin
                    state <= HOLD;
                end
            end

            if (accept) begin
                if (info.legal) begin
                    val_q   <= info.nibble;
                    valid_q <= 1'b1;
                    blank_q <= 1'b0;
                    cnt_q   <= (cnt_q == 4'd9) ? 4'd0 : cnt_q + 4'd1;
                end else if (info.is_blank) begin
                    blank_q <= 1'b1;
                end else begin
                    err_q   <= 1'b1;
                    blank_q <= 1'b0;
                end
            end
        end
    end

    assign bus.val   = val_q;
    assign bus.valid = valid_q;
    assign bus.err   = err_q;
    assign bus.blank = blank_q;
    assign bus.cnt   = cnt_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: table of held patterns plus hand sequences for en gaps and mid-run reset.
// Expected events are queued at drive time and matched (kind, values, edge index) when pulses appear.
module tb_seg7_reader;

    localparam int SC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_reader_if bus();

    seg7_reader #(.STABLE_CYCLES(SC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       rst_before;
        logic [6:0] hin;
        int         hold;
        int         ev;      // 0 none, 1 valid, 2 err
        logic [3:0] val;
        logic [3:0] cnt;
        logic       blank;
    } vec_t;

    typedef struct {
        int         ev;
        logic [3:0] val;
        logic [3:0] cnt;
        logic       blank;
        int         at_edge;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   edge_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic push_exp(input int ev, input logic [3:0] v, input logic [3:0] c,
                            input logic b, input int at);
        exp_t e;
        e.ev = ev; e.val = v; e.cnt = c; e.blank = b; e.at_edge = at;
        q.push_back(e);
    endtask

    task automatic chk_state(input string tag, input logic [3:0] v, input logic [3:0] c, input logic b);
        chk({tag, "_val"},   int'(bus.val),   int'(v));
        chk({tag, "_cnt"},   int'(bus.cnt),   int'(c));
        chk({tag, "_blank"}, int'(bus.blank), int'(b));
    endtask

    // Event monitor: sampled 1 ns after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        int   ev_now;
        edge_cnt++;
        #1;
        if (bus.valid && bus.err) chk("valid_and_err", 1, 0);
        if (bus.valid || bus.err) begin
            ev_now = bus.valid ? 1 : 2;
            if (q.size() == 0) begin
                chk("unexpected_event", ev_now, 0);
            end else begin
                e = q.pop_front();
                chk("ev_kind",  ev_now,           e.ev);
                chk("ev_edge",  edge_cnt,         e.at_edge);
                chk("ev_val",   int'(bus.val),    int'(e.val));
                chk("ev_cnt",   int'(bus.cnt),    int'(e.cnt));
                chk("ev_blank", int'(bus.blank),  int'(e.blank));
            end
        end
    end

    vec_t vecs[$];

    initial begin
        logic [6:0] digs [10];
        logic [3:0] c;
        int         start;

        digs = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

        vecs.push_back('{1'b0, 7'b1111111, 20, 0, 4'd0, 4'd0, 1'b1});
        vecs.push_back('{1'b0, 7'b0100100, 14, 1, 4'd2, 4'd1, 1'b0});
        c = 4'd0;
        for (int d = 0; d < 11; d++) begin
            c = (c == 4'd9) ? 4'd0 : c + 4'd1;
            vecs.push_back('{(d == 0), digs[d % 10], 6, 1, 4'(d % 10), c, 1'b0});
        end
        vecs.push_back('{1'b0, 7'b1111111, 4, 0, 4'd0, 4'd1, 1'b1});
        vecs.push_back('{1'b0, 7'b0101010, 4, 2, 4'd0, 4'd1, 1'b0});
        vecs.push_back('{1'b0, 7'b0001000, 6, 1, 4'hA, 4'd2, 1'b0});
        vecs.push_back('{1'b0, 7'b0110000, 2, 0, 4'hA, 4'd2, 1'b0});
        vecs.push_back('{1'b0, 7'b0000000, 1, 0, 4'hA, 4'd2, 1'b0});
        vecs.push_back('{1'b0, 7'b0110000, 4, 1, 4'd3, 4'd3, 1'b0});
        vecs.push_back('{1'b0, 7'b0000000, 1, 0, 4'd3, 4'd3, 1'b0});
        vecs.push_back('{1'b0, 7'b0110000, 6, 1, 4'd3, 4'd4, 1'b0});

        bus.hin = 7'b1111111;
        bus.en  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", int'(bus.valid), 0);
        chk("rst_err",   int'(bus.err),   0);
        chk_state("rst", 4'd0, 4'd0, 1'b1);

        foreach (vecs[i]) begin
            if (vecs[i].rst_before) begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
            bus.hin = vecs[i].hin;
            bus.en  = 1'b1;
            if (vecs[i].ev != 0)
                push_exp(vecs[i].ev, vecs[i].val, vecs[i].cnt, vecs[i].blank, edge_cnt + SC);
            repeat (vecs[i].hold) @(negedge clk);
            chk_state($sformatf("row%0d", i), vecs[i].val, vecs[i].cnt, vecs[i].blank);
        end

        // en gaps: only the four enabled edges count.
        bus.hin = 7'b0011001;
        start = edge_cnt;
        push_exp(1, 4'd4, 4'd5, 1'b0, start + 7);
        for (int k = 0; k < 7; k++) begin
            bus.en = (k % 2 == 0);
            @(negedge clk);
        end
        bus.en = 1'b1;
        repeat (6) @(negedge clk);
        chk_state("en_gap", 4'd4, 4'd5, 1'b0);

        // Reset at stab=2 discards the run; the pattern then needs a full new run.
        bus.hin = 7'b1111000;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", int'(bus.valid), 0);
        chk("midrst_err",   int'(bus.err),   0);
        chk_state("midrst", 4'd0, 4'd0, 1'b1);
        rst = 1'b0;
        push_exp(1, 4'd7, 4'd1, 1'b0, edge_cnt + SC);
        repeat (6) @(negedge clk);
        chk_state("post_rst", 4'd7, 4'd1, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_drain", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_reader.md
# seg7_reader

Read-back decoder for active-low 7-segment display patterns: the inverse of the team's hex-to-segment encoder. It samples a 7-bit segment bus and filters it for stability. Each newly stable pattern is converted back to a 4-bit value, with pulsed valid/error events and a wrapping BCD count of accepted digits. It is used as a display monitor and self-check next to the counter/display path, with its input fed from the encoder output.

## Interface
- STABLE_CYCLES, 4: consecutive identical enabled samples required to accept a pattern; legal range 1..255.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- hin  in  7  segment pattern, active-low, bit0=a … bit6=g (digit 0 = 7'b1000000).
- en  in  1  sample enable; hin is ignored when low.
- val  out  4  last legally decoded value.
- valid  out  1  one-cycle pulse: a legal pattern was accepted; val already updated.
- err  out  1  one-cycle pulse: an illegal, non-blank pattern was accepted; val unchanged.
- blank  out  1  level: last accepted pattern was 7'b1111111.
- cnt  out  4  BCD count of legal acceptances, 0..9, wraps.

## Operation
- Legal set: the 16 team encodings: 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000, A 0001000, b 0000011, C 1000110, d 0100001, E 0000110, F 0001110. Blank is 1111111. Any other pattern is illegal.
- Internal state: candidate pattern `cand` (7b), run counter `stab` (8b), FSM {TRACK, HOLD}.
- Edge with en=1 and hin != cand:
  - cand<=hin, stab<=1, state<=TRACK.
  - If STABLE_CYCLES==1, accept immediately instead (see below).
- Edge with en=1, hin == cand, state TRACK: stab<=stab+1. When stab+1 == STABLE_CYCLES, accept and go to HOLD.
- Edge with en=1, hin == cand, state HOLD: no action, no events.
- Edge with en=0: cand, stab and state hold. valid/err are 0.
- Acceptance, registered at the accepting edge:
  - Legal: val<=code, valid<=1, blank<=0, cnt<=(cnt==9)?0:cnt+1.
  - Blank: blank<=1, no pulse, val and cnt hold.
  - Illegal: err<=1, blank<=0, val and cnt hold.
- valid and err are never high together and are never high for two consecutive cycles from one acceptance.
- Glitch handling: if hin goes X then back to the previously accepted pattern P, P restarts its run and is accepted again. That is a new valid event and cnt increments.
- Unequal hin values on every edge never produce an acceptance (when STABLE_CYCLES>1).

## Timing
- Reset values: val=0, valid=0, err=0, blank=1, cnt=0, cand=1111111, stab=0, state=HOLD. A blank input after reset produces no event.
- rst has priority over all other activity. Reset mid-TRACK discards the candidate with no pulse.
- Latency with en held high: hin changes before edge 1 and stays stable; valid/err is high in the cycle after edge STABLE_CYCLES. For STABLE_CYCLES=1 it is high in the cycle after edge 1.
- With en gaps, only enabled edges count toward STABLE_CYCLES.
- All outputs are registered. No combinational path from hin or en to any output.

## Structure
- Shared package `seg7_pkg`:
  - SEG_0..SEG_F and SEG_BLANK constants, the same values used by the encoder.
  - The {TRACK, HOLD} state encoding.
- Sub-module `seg7_lookup`: combinational pattern -> {legal, is_blank, nibble}. Also reusable by other display checkers.
- Top level: the FSM, the stab counter, the output registers, and the BCD counter.

## Test plan
- Reset, STABLE_CYCLES=4, hin=1111111 held 20 cycles -> no valid/err, blank=1, val=0, cnt=0.
- hin=0100100 held -> valid pulse in cycle after 4th edge, val=2, blank=0, cnt=1. Holding a further 10 cycles -> no additional pulse.
- Apply digits 0..9 then 0 again, each held 6 cycles -> 11 valid pulses, val tracks the digit, cnt sequence 1..9,0,1.
- hin=1111111->0101010 (illegal) held 4 cycles -> err pulse, val unchanged, cnt unchanged. Then 0001000 -> valid, val=A.
- Sequence 3 for 2 cycles, 8 for 1 cycle, 3 for 4 cycles -> exactly one valid, val=3; the 8 is never accepted.
- Hold 0011001 with en toggling 1,0,1,0,1,0,1 -> valid after the 4th enabled edge, val=4. Assert rst at stab=2 during a later 1111000 run -> outputs return to reset values, no pulse.
